// File: rtl/ibex_defines.sv
// Shared CSR definitions used by the Ibex performance-counter block.
package ibex_defines;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // mcountinhibit occupies offset 0 of the mhpmevent group (0x320..0x33F)
  localparam logic [11:0] CSR_OFF_MHPMEVENT      = 12'h320;
  localparam logic [11:0] CSR_MCOUNTINHIBIT_MASK = 12'hFE0;
  localparam logic [11:0] CSR_OFF_MCOUNTER       = 12'hB00;
  localparam logic [11:0] CSR_OFF_MCOUNTERH      = 12'hB80;
  localparam logic [11:0] CSR_MCOUNTER_MASK      = 12'hFE0;

  // Read-modify-write result of a CSR operation on a 32-bit view
  function automatic logic [31:0] csr_rmw(input csr_op_e    op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] operand);
    logic [31:0] res;
    case (op)
      CSR_OP_WRITE: res = operand;
      CSR_OP_SET:   res = old_val | operand;
      CSR_OP_CLEAR: res = old_val & ~operand;
      default:      res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ibex_counter.sv
// One performance counter: increment, 32-bit low/high writes, wrap and overflow pulse.
module ibex_counter #(
  parameter int unsigned CounterWidth = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        incr_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] val_o,
  output logic        ovf_o
);

  logic [CounterWidth-1:0] r_cnt;
  logic                    r_ovf;
  logic [CounterWidth-1:0] w_wr_val;

  // Merge the written half into the current value; bits beyond the width simply do not exist
  always_comb begin
    w_wr_val = r_cnt;
    if (we_lo_i) w_wr_val[31:0] = wdata_i;
    for (int b = 32; b < CounterWidth; b++) begin
      if (we_hi_i) w_wr_val[b] = wdata_i[b-32];
    end
  end

  // A write wins over the increment; the overflow pulse lasts exactly one cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (we_lo_i || we_hi_i) begin
        r_cnt <= w_wr_val;
      end else if (incr_i) begin
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= &r_cnt;
      end
    end
  end

  assign val_o = 64'(r_cnt);
  assign ovf_o = r_ovf;

endmodule

// File: rtl/ibex_hpm_counters.sv
// Machine counters (mcycle, minstret, mhpmcounter3..) with mcountinhibit and mhpmevent CSRs.
module ibex_hpm_counters
  import ibex_defines::*;
#(
  parameter int unsigned MHPMCounterNum   = 8,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      csr_access_i,
  input  csr_op_e                   csr_op_i,
  input  logic [11:0]               csr_addr_i,
  input  logic [31:0]               csr_wdata_i,
  output logic [31:0]               csr_rdata_o,
  output logic                      csr_illegal_o,
  input  logic [NumEvents-1:0]      event_i,
  input  logic                      instr_ret_i,
  input  logic                      debug_mode_i,
  output logic [MHPMCounterNum+2:0] ovf_o
);

  localparam int unsigned       NumCnt      = MHPMCounterNum + 3;
  localparam int unsigned       NumEvReg    = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;
  localparam logic [NumCnt-1:0] InhibitMask = ~(NumCnt'(2));

  logic                 w_grp_evt, w_grp_lo, w_grp_hi, w_hit, w_idx_ok, w_wr;
  logic [4:0]           w_idx;
  logic [31:0]          w_rdata, w_new;
  logic [31:0]          w_rd_evt [32];
  logic [31:0]          w_rd_lo  [32];
  logic [31:0]          w_rd_hi  [32];
  logic [63:0]          w_cnt_val [NumCnt];
  logic [NumCnt-1:0]    w_incr, w_we_lo, w_we_hi;
  logic [NumCnt-1:0]    r_inhibit;
  logic [NumEvents-1:0] r_mhpmevent [NumEvReg];
  logic                 w_unused;

  // Address decode and read mux; unimplemented targets read as zero
  always_comb begin
    w_grp_evt = (csr_addr_i & CSR_MCOUNTINHIBIT_MASK) == CSR_OFF_MHPMEVENT;
    w_grp_lo  = (csr_addr_i & CSR_MCOUNTER_MASK) == CSR_OFF_MCOUNTER;
    w_grp_hi  = (csr_addr_i & CSR_MCOUNTER_MASK) == CSR_OFF_MCOUNTERH;
    w_hit     = w_grp_evt || w_grp_lo || w_grp_hi;
    w_idx     = csr_addr_i[4:0];
    // index 1 is the time CSR, and there is no mhpmevent2
    w_idx_ok  = (w_idx != 5'd1) && (32'(w_idx) < NumCnt) && !(w_grp_evt && (w_idx == 5'd2));
    for (int i = 0; i < 32; i++) begin
      w_rd_evt[i] = '0;
      w_rd_lo[i]  = '0;
      w_rd_hi[i]  = '0;
    end
    w_rd_evt[0] = 32'(r_inhibit);
    for (int k = 0; k < MHPMCounterNum; k++) w_rd_evt[k+3] = 32'(r_mhpmevent[k]);
    for (int i = 0; i < NumCnt; i++) begin
      w_rd_lo[i] = w_cnt_val[i][31:0];
      w_rd_hi[i] = w_cnt_val[i][63:32];
    end
    w_rdata = '0;
    if (w_idx_ok) begin
      if (w_grp_evt)     w_rdata = w_rd_evt[w_idx];
      else if (w_grp_lo) w_rdata = w_rd_lo[w_idx];
      else if (w_grp_hi) w_rdata = w_rd_hi[w_idx];
    end
  end

  assign csr_rdata_o   = w_rdata;
  assign csr_illegal_o = csr_access_i && w_hit && !w_idx_ok;
  assign w_wr          = csr_access_i && w_hit && w_idx_ok && (csr_op_i != CSR_OP_READ);
  assign w_new         = csr_rmw(csr_op_i, w_rdata, csr_wdata_i);

  // Configuration registers; new values govern counting from the following edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inhibit <= '0;
      for (int k = 0; k < NumEvReg; k++) r_mhpmevent[k] <= '0;
    end else if (w_wr && w_grp_evt) begin
      if (w_idx == 5'd0) r_inhibit <= w_new[NumCnt-1:0] & InhibitMask;
      for (int k = 0; k < MHPMCounterNum; k++) begin
        if (int'(w_idx) == k + 3) r_mhpmevent[k] <= w_new[NumEvents-1:0];
      end
    end
  end

  // Per-counter increment qualifiers and half-word write strobes
  always_comb begin
    w_incr  = '0;
    w_we_lo = '0;
    w_we_hi = '0;
    w_incr[0] = !r_inhibit[0] && !debug_mode_i;
    w_incr[2] = instr_ret_i && !r_inhibit[2] && !debug_mode_i;
    for (int k = 0; k < MHPMCounterNum; k++) begin
      w_incr[k+3] = (|(event_i & r_mhpmevent[k])) && !r_inhibit[k+3] && !debug_mode_i;
    end
    for (int i = 0; i < NumCnt; i++) begin
      w_we_lo[i] = w_wr && w_grp_lo && (int'(w_idx) == i);
      w_we_hi[i] = w_wr && w_grp_hi && (int'(w_idx) == i);
    end
  end

  for (genvar i = 0; i < NumCnt; i++) begin : g_cnt
    if (i == 1) begin : g_time
      assign w_cnt_val[i] = '0;
      assign ovf_o[i]     = 1'b0;
    end else begin : g_ctr
      localparam int unsigned Width = (i < 3) ? 64 : MHPMCounterWidth;
      ibex_counter #(
        .CounterWidth (Width)
      ) u_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .incr_i  (w_incr[i]),
        .we_lo_i (w_we_lo[i]),
        .we_hi_i (w_we_hi[i]),
        .wdata_i (w_new),
        .val_o   (w_cnt_val[i]),
        .ovf_o   (ovf_o[i])
      );
    end
  end

  assign w_unused = ^{w_incr[1], w_we_lo[1], w_we_hi[1]};

endmodule

// File: tb/tb_ibex_hpm_counters.sv
// Scoreboard bench for ibex_hpm_counters against an arithmetic reference model.
module tb_ibex_hpm_counters;
  import ibex_defines::*;

  localparam int N  = 8;
  localparam int W  = 40;
  localparam int NE = 16;
  localparam int NC = N + 3;

  logic          clk_i        = 1'b0;
  logic          rst_i        = 1'b1;
  logic          csr_access_i = 1'b0;
  csr_op_e       csr_op_i     = CSR_OP_READ;
  logic [11:0]   csr_addr_i   = 12'hB00;
  logic [31:0]   csr_wdata_i  = '0;
  logic [31:0]   csr_rdata_o;
  logic          csr_illegal_o;
  logic [NE-1:0] event_i      = '0;
  logic          instr_ret_i  = 1'b0;
  logic          debug_mode_i = 1'b0;
  logic [NC-1:0] ovf_o;

  ibex_hpm_counters #(
    .MHPMCounterNum   (N),
    .MHPMCounterWidth (W),
    .NumEvents        (NE)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .csr_access_i  (csr_access_i),
    .csr_op_i      (csr_op_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o),
    .event_i       (event_i),
    .instr_ret_i   (instr_ret_i),
    .debug_mode_i  (debug_mode_i),
    .ovf_o         (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   rd;
    logic          ill;
    logic [NC-1:0] ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counters as plain 64-bit numbers indexed by CSR index
  longint unsigned m_cnt [32];
  int unsigned     m_inh;
  int unsigned     m_evt [32];
  logic [NC-1:0]   m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned cnt_max(input int idx);
    if (idx < 3) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << W) - 64'd1;
  endfunction

  function automatic int unsigned inh_mask();
    int unsigned m = 0;
    for (int i = 0; i < NC; i++) if (i != 1) m = m | (32'd1 << i);
    return m;
  endfunction

  function automatic void mread(input logic [11:0] a, output logic [31:0] rd, output bit hit,
                                output bit legal, output int grp, output int idx);
    int ia;
    ia  = int'(a);
    rd  = '0;
    hit = 1'b1;
    grp = 0;
    idx = 0;
    if (ia >= 'h320 && ia < 'h340)      begin grp = 0; idx = ia - 'h320; end
    else if (ia >= 'hB00 && ia < 'hB20) begin grp = 1; idx = ia - 'hB00; end
    else if (ia >= 'hB80 && ia < 'hBA0) begin grp = 2; idx = ia - 'hB80; end
    else hit = 1'b0;
    legal = hit && (idx != 1) && (idx < NC) && !(grp == 0 && idx == 2);
    if (legal) begin
      case (grp)
        0:       rd = (idx == 0) ? m_inh : m_evt[idx];
        1:       rd = m_cnt[idx][31:0];
        default: rd = m_cnt[idx][63:32];
      endcase
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      m_evt[i] = 0;
    end
    m_inh = 0;
    m_ovf = '0;
  endtask

  task automatic model_step(input bit acc, input csr_op_e op, input logic [11:0] a,
                            input logic [31:0] wd, input logic [NE-1:0] ev, input bit ir, input bit dbg);
    logic [31:0]   rd, nv;
    bit            hit, legal, wr;
    int            grp, idx;
    bit            inc [NC];
    logic [NC-1:0] novf;
    mread(a, rd, hit, legal, grp, idx);
    wr = acc && legal && (op != CSR_OP_READ);
    case (op)
      CSR_OP_WRITE: nv = wd;
      CSR_OP_SET:   nv = rd | wd;
      CSR_OP_CLEAR: nv = rd & ~wd;
      default:      nv = rd;
    endcase
    for (int i = 0; i < NC; i++) begin
      if (i == 0)      inc[i] = 1'b1;
      else if (i == 2) inc[i] = ir;
      else if (i == 1) inc[i] = 1'b0;
      else             inc[i] = ((ev & m_evt[i][NE-1:0]) != 0);
      inc[i] = inc[i] && !dbg && !m_inh[i];
    end
    novf = '0;
    for (int i = 0; i < NC; i++) begin
      if (i == 1) continue;
      if (wr && grp == 1 && idx == i)      m_cnt[i] = {m_cnt[i][63:32], nv} & cnt_max(i);
      else if (wr && grp == 2 && idx == i) m_cnt[i] = {nv, m_cnt[i][31:0]} & cnt_max(i);
      else if (inc[i]) begin
        if (m_cnt[i] == cnt_max(i)) begin
          m_cnt[i] = 0;
          novf[i]  = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (wr && grp == 0) begin
      if (idx == 0) m_inh = nv & inh_mask();
      else          m_evt[idx] = nv & ((32'd1 << NE) - 32'd1);
    end
    m_ovf = novf;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the expected response
  task automatic cyc(input bit rst, input bit acc, input csr_op_e op, input logic [11:0] a,
                     input logic [31:0] wd, input logic [NE-1:0] ev, input bit ir, input bit dbg);
    exp_t e;
    bit   hit, legal;
    int   grp, idx;
    @(negedge clk_i);
    rst_i        = rst;
    csr_access_i = acc;
    csr_op_i     = op;
    csr_addr_i   = a;
    csr_wdata_i  = wd;
    event_i      = ev;
    instr_ret_i  = ir;
    debug_mode_i = dbg;
    if (rst) model_reset();
    mread(a, e.rd, hit, legal, grp, idx);
    e.ill = acc && hit && !legal;
    e.ovf = m_ovf;
    sb_q.push_back(e);
    if (!rst) model_step(acc, op, a, wd, ev, ir, dbg);
  endtask

  task automatic idle();
    cyc(0, 0, CSR_OP_READ, 12'hB00, 32'h0, '0, 0, 0);
  endtask

  task automatic rd(input logic [11:0] a);
    cyc(0, 1, CSR_OP_READ, a, 32'h0, '0, 0, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cyc(0, 1, CSR_OP_WRITE, a, d, '0, 0, 0);
  endtask

  // Directed constant checks of the currently presented cycle
  task automatic expect_now(input string name, input logic [31:0] exp_rd, input logic exp_ill);
    #2;
    chk({name, "_rdata"}, 64'(csr_rdata_o), 64'(exp_rd));
    chk({name, "_illegal"}, 64'(csr_illegal_o), 64'(exp_ill));
  endtask

  // Monitor: compare every presented cycle with the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_rdata", 64'(csr_rdata_o), 64'(e.rd));
        chk("sb_illegal", 64'(csr_illegal_o), 64'(e.ill));
        chk("sb_ovf", 64'(ovf_o), 64'(e.ovf));
      end
    end
  end

  initial begin
    bit            r_rst, r_acc, r_ir, r_dbg;
    csr_op_e       r_op;
    logic [11:0]   r_a;
    logic [31:0]   r_wd;
    logic [NE-1:0] r_ev;
    int            sel;

    model_reset();
    // reset held with accesses in flight
    cyc(1, 1, CSR_OP_WRITE, 12'hB00, 32'hDEAD_BEEF, '1, 1, 0);
    cyc(1, 1, CSR_OP_WRITE, 12'h320, 32'hFFFF_FFFF, '1, 1, 0);
    expect_now("in_reset", 32'h0, 1'b0);
    cyc(1, 0, CSR_OP_READ, 12'hB02, 32'h0, '0, 0, 0);
    expect_now("in_reset_minstret", 32'h0, 1'b0);

    // release, then ten edges of idle
    for (int i = 0; i < 10; i++) idle();
    rd(12'hB00); expect_now("mcycle_10", 32'd10, 1'b0);
    rd(12'hB02); expect_now("minstret_0", 32'd0, 1'b0);

    // hpm3 wrap at 40 bits
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0000_00FF);
    wr(12'h323, 32'h1);
    cyc(0, 0, CSR_OP_READ, 12'hB03, 32'h0, NE'(1), 0, 0);
    rd(12'hB03); expect_now("hpm3_wrap", 32'h0, 1'b0);
    chk("ovf3_pulse", 64'(ovf_o[3]), 64'd1);
    rd(12'hB83); expect_now("hpm3h_wrap", 32'h0, 1'b0);
    chk("ovf3_single", 64'(ovf_o[3]), 64'd0);

    // write beats increment
    cyc(0, 1, CSR_OP_WRITE, 12'hB02, 32'h100, '0, 1, 0);
    rd(12'hB02); expect_now("minstret_wr_prio", 32'h100, 1'b0);

    // inhibit mcycle and minstret
    wr(12'h320, 32'h5);
    wr(12'hB00, 32'h1234);
    wr(12'hB80, 32'h7);
    wr(12'hB02, 32'h55);
    for (int i = 0; i < 4; i++) cyc(0, 0, CSR_OP_READ, 12'hB00, 32'h0, '0, 1, 0);
    rd(12'hB00); expect_now("mcycle_inh", 32'h1234, 1'b0);
    rd(12'hB80); expect_now("mcycleh_inh", 32'h7, 1'b0);
    rd(12'hB02); expect_now("minstret_inh", 32'h55, 1'b0);
    rd(12'h320); expect_now("mcountinhibit", 32'h5, 1'b0);
    cyc(0, 1, CSR_OP_CLEAR, 12'h320, 32'h5, '0, 0, 0);
    rd(12'hB00); expect_now("mcycle_clr_edge", 32'h1234, 1'b0);
    rd(12'hB00); expect_now("mcycle_resume", 32'h1235, 1'b0);

    // illegal and out-of-range accesses
    rd(12'hB0B); expect_now("idx_over", 32'h0, 1'b1);
    wr(12'hB01, 32'hFFFF_FFFF); expect_now("time_wr", 32'h0, 1'b1);
    rd(12'hB81); expect_now("timeh_rd", 32'h0, 1'b1);
    cyc(0, 0, CSR_OP_READ, 12'hB01, 32'h0, '0, 0, 0); expect_now("no_access", 32'h0, 1'b0);
    rd(12'h5A0); expect_now("outside", 32'h0, 1'b0);
    cyc(0, 1, CSR_OP_SET, 12'h33F, 32'hFFFF_FFFF, '0, 0, 0); expect_now("evt_over", 32'h0, 1'b1);

    // debug freeze
    wr(12'h324, 32'hFFFF);
    for (int i = 0; i < 5; i++) cyc(0, 0, CSR_OP_READ, 12'hB04, 32'h0, '1, 1, 1);
    cyc(0, 1, CSR_OP_READ, 12'hB04, 32'h0, '1, 0, 0); expect_now("hpm4_dbg", 32'h0, 1'b0);
    rd(12'hB04); expect_now("hpm4_resume", 32'h1, 1'b0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_acc = $urandom_range(0, 1) != 0;
      r_op  = csr_op_e'($urandom_range(0, 3));
      sel   = $urandom_range(0, 9);
      if (sel < 3)      r_a = 12'h320 + 12'($urandom_range(0, 31));
      else if (sel < 6) r_a = 12'hB00 + 12'($urandom_range(0, 31));
      else if (sel < 9) r_a = 12'hB80 + 12'($urandom_range(0, 31));
      else              r_a = 12'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       r_wd = 32'hFFFF_FFFF;
        1:       r_wd = 32'h0000_00FF;
        default: r_wd = $urandom;
      endcase
      r_ev  = NE'($urandom & $urandom);
      r_ir  = $urandom_range(0, 1) != 0;
      r_dbg = ($urandom_range(0, 9) == 0);
      cyc(r_rst, r_acc, r_op, r_a, r_wd, r_ev, r_ir, r_dbg);
    end

    repeat (2) @(negedge clk_i);
    #3;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_hpm_counters.md
IBEX_HPM_COUNTERS -- requirements
Module: ibex_hpm_counters

Interface
REQ-001 SHALL have parameter MHPMCounterNum, default 8, meaning the number of implemented mhpmcounter3.. counters (legal range 0..29).
REQ-002 SHALL have parameter MHPMCounterWidth, default 40, meaning the width of each mhpmcounter in bits (legal range 32..64); mcycle and minstret are always 64 bits.
REQ-003 SHALL have parameter NumEvents, default 16, meaning the width of the event input vector (legal range 1..32).
REQ-004 clk_i  in  1  sole clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 csr_access_i  in  1  CSR access strobe, one cycle per access.
REQ-007 csr_op_i  in  2  operation, csr_op_e (READ/WRITE/SET/CLEAR).
REQ-008 csr_addr_i  in  12  CSR address.
REQ-009 csr_wdata_i  in  32  write/set/clear operand.
REQ-010 csr_rdata_o  out  32  read data, combinational from current register state.
REQ-011 csr_illegal_o  out  1  access hit the counter space but targets an unimplemented or forbidden CSR.
REQ-012 event_i  in  NumEvents  per-cycle event pulses.
REQ-013 instr_ret_i  in  1  one instruction retired this cycle.
REQ-014 debug_mode_i  in  1  core in debug mode; freezes all counting.
REQ-015 ovf_o  out  MHPMCounterNum+3  one-cycle overflow pulse per counter index (bit 1 always 0).

Function
REQ-016 SHALL decode mcountinhibit (0x320), mhpmevent3+k (0x323+k), mcycle/minstret/mhpmcounter (0xB00+i) and their upper halves (0xB80+i), using mask 0xFE0 for the counter groups.
REQ-017 SHALL increment mcycle each cycle unless mcountinhibit[0] is set or debug_mode_i is high.
REQ-018 SHALL increment minstret when instr_ret_i is high, unless mcountinhibit[2] is set or debug_mode_i is high.
REQ-019 SHALL increment mhpmcounter(3+k) by exactly 1 when |(event_i & mhpmevent(3+k)[NumEvents-1:0]) is high, unless mcountinhibit[3+k] is set or debug_mode_i is high.
REQ-020 SHALL apply WRITE/SET/CLEAR as a read-modify-write whose result is visible on csr_rdata_o the following cycle; READ SHALL modify no state.
REQ-021 A low-half write SHALL leave the upper half unchanged and vice versa; counter bits at or above MHPMCounterWidth SHALL read 0 and ignore writes.
REQ-022 A CSR write to a counter SHALL take precedence over its increment in the same cycle (the written value is stored, not the written value plus 1).
REQ-023 A write to mcountinhibit or mhpmevent SHALL affect counting from the next cycle onward.
REQ-024 mcountinhibit bit 1 and all bits above MHPMCounterNum+2 SHALL be hardwired 0; mhpmevent bits at or above NumEvents SHALL read 0.
REQ-025 On increment from all-ones, a counter SHALL wrap to 0 and pulse its ovf_o bit high for exactly one cycle.
REQ-026 Access to index 1 (time) or to an index >= MHPMCounterNum+3 SHALL assert csr_illegal_o in the same cycle, return rdata 0, and modify no state.
REQ-027 csr_illegal_o SHALL be 0 when csr_access_i is low or when the address lies outside the decoded ranges.

Reset
REQ-028 While rst_i is high, all counters, mcountinhibit, mhpmevent and ovf_o SHALL be 0, and no increment or CSR write SHALL take effect; csr_rdata_o then reads 0 for every counter address.
REQ-029 Reset asserted mid-access SHALL discard the access; the first increment SHALL occur on the first rising edge after rst_i deasserts.

Structure
REQ-030 Address constants CSR_OFF_MHPMEVENT (0x320) and CSR_MCOUNTINHIBIT_MASK, together with the existing csr_op_e, SHALL reside in the shared ibex_defines package.
REQ-031 SHALL instantiate one sub-module, ibex_counter (parameter CounterWidth), providing increment, low/high write, wrap and overflow pulse, once per counter.

Verification
REQ-032 Reset, then idle 10 cycles -> mcycle reads 10; minstret reads 0; csr_illegal_o stays 0.
REQ-033 Write mhpmcounter3 = 0xFFFFFFFF and mhpmcounter3h = 0xFF (width 40), mhpmevent3 = 0x1, pulse event_i[0] once -> counter reads 0, ovf_o[3] high for 1 cycle.
REQ-034 Write minstret = 0x100 in the same cycle as instr_ret_i = 1 -> minstret reads 0x100 next cycle, not 0x101.
REQ-035 Set mcountinhibit = 0x5, hold instr_ret_i high for 4 cycles -> mcycle and minstret are unchanged, and mcycleh is unchanged.
REQ-036 MHPMCounterNum = 2, read 0xB05 and 0xB01 -> csr_illegal_o = 1, rdata = 0, no state change.
REQ-037 Assert debug_mode_i for 5 cycles with event_i all-ones -> no counter changes; counting resumes the cycle after deassertion.
